// File: rtl/g729_mem_map_pkg.sv
// Shared scratch-memory map and controller state encoding for the
// LSP interpolation / LSP-to-Az sequencing block.
package g729_mem_map_pkg;

    localparam logic [6:0] LSP_OLD_BASE_C = 7'h60;
    localparam logic [6:0] LSP_NEW_BASE_C = 7'h6A;
    localparam logic [6:0] LSP_IN_BASE_C  = 7'h50;
    localparam logic [6:0] LSP_A_BASE_C   = 7'h40;
    localparam logic [6:0] AZ_OUT_BASE_C  = 7'h00;

    localparam logic [3:0] LSP_ORDER = 4'd10;  // LSP words per frame
    localparam logic [3:0] AZ_LEN    = 4'd11;  // Az coefficients per subframe
    localparam logic [6:0] AZ_SUB2_OFS = 7'd11;

    typedef enum logic [3:0] {
        IDLE,
        INTERP,
        AZ1,
        WAIT1,
        COPY1,
        COPYN,
        AZ2,
        WAIT2,
        COPY2,
        DONE
    } qlpc_state_e;

    // Midpoint of two Q15 LSPs; halving each operand first keeps the sum
    // inside 16 bits, so no saturation is needed.
    function automatic logic [31:0] lsp_avg(input logic [15:0] old_v,
                                            input logic [15:0] new_v);
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic signed [15:0] s;
        a = $signed(old_v) >>> 1;
        b = $signed(new_v) >>> 1;
        s = a + b;
        return {{16{s[15]}}, s};
    endfunction

endpackage

// File: rtl/int_qlpc_ctrl_copy.sv
// Word-per-cycle scratch copy: reads src+idx and writes dst+idx in the same
// cycle (read data returns combinationally). start_i is held high for the
// whole copy phase; done_o flags the last word.
module scratch_copy (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_i,
    input  logic [6:0]  src_base_i,
    input  logic [6:0]  dst_base_i,
    input  logic [3:0]  len_i,
    output logic [6:0]  rd_addr_o,
    input  logic [31:0] rd_data_i,
    output logic [6:0]  wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic        wr_en_o,
    output logic        done_o
);

    logic [3:0] idx_q;
    logic [3:0] idx_d;
    logic       last;

    assign last = (idx_q == len_i - 4'd1);

    // Index advances while active and rewinds after the last word or when idle.
    always_comb begin
        idx_d = '0;
        if (start_i && !last) idx_d = idx_q + 4'd1;
    end

    // Index register.
    always_ff @(posedge clock) begin
        if (reset) idx_q <= '0;
        else       idx_q <= idx_d;
    end

    // Port drive is zero whenever the copy is not active.
    always_comb begin
        rd_addr_o = '0;
        wr_addr_o = '0;
        wr_data_o = '0;
        wr_en_o   = 1'b0;
        done_o    = 1'b0;
        if (start_i) begin
            rd_addr_o = src_base_i + {3'b000, idx_q};
            wr_addr_o = dst_base_i + {3'b000, idx_q};
            wr_data_o = rd_data_i;
            wr_en_o   = 1'b1;
            done_o    = last;
        end
    end

endmodule

// File: rtl/int_qlpc_ctrl.sv
// Sequences LSP interpolation, two LSP-to-Az engine runs and the copies of
// their results into the two-subframe Az output area of scratch memory.
module int_qlpc_ctrl
    import g729_mem_map_pkg::*;
#(
    parameter logic [6:0] LSP_OLD_BASE = LSP_OLD_BASE_C,
    parameter logic [6:0] LSP_NEW_BASE = LSP_NEW_BASE_C,
    parameter logic [6:0] LSP_IN_BASE  = LSP_IN_BASE_C,
    parameter logic [6:0] LSP_A_BASE   = LSP_A_BASE_C,
    parameter logic [6:0] AZ_OUT_BASE  = AZ_OUT_BASE_C
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    output logic        az_start,
    input  logic        az_done,
    output logic        mem_grant,
    output logic [6:0]  scratch_mem_read_addr,
    input  logic [31:0] scratch_mem_in,
    output logic [6:0]  scratch_mem_write_addr,
    output logic [31:0] scratch_mem_out,
    output logic        scratch_mem_write_en
);

    qlpc_state_e state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        phase_q, phase_d;   // 0: fetch old LSP, 1: fetch new + write
    logic [15:0] old_q, old_d;

    logic        cp_en;
    logic [6:0]  cp_src, cp_dst;
    logic [3:0]  cp_len;
    logic [6:0]  cp_raddr, cp_waddr;
    logic [31:0] cp_wdata;
    logic        cp_we, cp_done;

    // Copy-phase source/destination selection, kept apart from the FSM so
    // the copy unit outputs feed the FSM without a combinational cycle.
    always_comb begin
        cp_en  = 1'b0;
        cp_src = '0;
        cp_dst = '0;
        cp_len = '0;
        case (state_q)
            COPY1: begin
                cp_en  = 1'b1;
                cp_src = LSP_A_BASE;
                cp_dst = AZ_OUT_BASE;
                cp_len = AZ_LEN;
            end
            COPYN: begin
                cp_en  = 1'b1;
                cp_src = LSP_NEW_BASE;
                cp_dst = LSP_IN_BASE;
                cp_len = LSP_ORDER;
            end
            COPY2: begin
                cp_en  = 1'b1;
                cp_src = LSP_A_BASE;
                cp_dst = AZ_OUT_BASE + AZ_SUB2_OFS;
                cp_len = AZ_LEN;
            end
            default: ;
        endcase
    end

    scratch_copy u_copy (
        .clock      (clock),
        .reset      (reset),
        .start_i    (cp_en),
        .src_base_i (cp_src),
        .dst_base_i (cp_dst),
        .len_i      (cp_len),
        .rd_addr_o  (cp_raddr),
        .rd_data_i  (scratch_mem_in),
        .wr_addr_o  (cp_waddr),
        .wr_data_o  (cp_wdata),
        .wr_en_o    (cp_we),
        .done_o     (cp_done)
    );

    // State, interpolation index/phase and old-LSP latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            phase_q <= 1'b0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            old_q   <= old_d;
        end
    end

    // Next state and all outputs; everything idles at zero by default.
    always_comb begin
        state_d                = state_q;
        idx_d                  = idx_q;
        phase_d                = phase_q;
        old_d                  = old_q;
        done                   = 1'b0;
        az_start               = 1'b0;
        mem_grant              = 1'b0;
        scratch_mem_read_addr  = '0;
        scratch_mem_write_addr = '0;
        scratch_mem_out        = '0;
        scratch_mem_write_en   = 1'b0;

        case (state_q)
            IDLE: begin
                idx_d   = '0;
                phase_d = 1'b0;
                if (start) state_d = INTERP;
            end

            INTERP: begin
                if (!phase_q) begin
                    scratch_mem_read_addr = LSP_OLD_BASE + {3'b000, idx_q};
                    old_d   = scratch_mem_in[15:0];
                    phase_d = 1'b1;
                end else begin
                    scratch_mem_read_addr  = LSP_NEW_BASE + {3'b000, idx_q};
                    scratch_mem_write_addr = LSP_IN_BASE + {3'b000, idx_q};
                    scratch_mem_out        = lsp_avg(old_q, scratch_mem_in[15:0]);
                    scratch_mem_write_en   = 1'b1;
                    phase_d                = 1'b0;
                    if (idx_q == LSP_ORDER - 4'd1) begin
                        idx_d   = '0;
                        state_d = AZ1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end

            AZ1, AZ2: begin
                az_start  = 1'b1;
                mem_grant = 1'b1;
                state_d   = (state_q == AZ1) ? WAIT1 : WAIT2;
            end

            WAIT1, WAIT2: begin
                mem_grant = 1'b1;
                if (az_done) state_d = (state_q == WAIT1) ? COPY1 : COPY2;
            end

            COPY1, COPYN, COPY2: begin
                scratch_mem_read_addr  = cp_raddr;
                scratch_mem_write_addr = cp_waddr;
                scratch_mem_out        = cp_wdata;
                scratch_mem_write_en   = cp_we;
                if (cp_done) begin
                    case (state_q)
                        COPY1:   state_d = COPYN;
                        COPYN:   state_d = AZ2;
                        default: state_d = DONE;
                    endcase
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_int_qlpc_ctrl.sv
// Directed bench for int_qlpc_ctrl: scratch memory model, LSP-to-Az engine
// stub with programmable latency, and hand-computed expected images.
module tb_int_qlpc_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic        az_start;
    logic        az_done;
    logic        mem_grant;
    logic [6:0]  scratch_mem_read_addr;
    logic [31:0] scratch_mem_in;
    logic [6:0]  scratch_mem_write_addr;
    logic [31:0] scratch_mem_out;
    logic        scratch_mem_write_en;

    logic        stub_done;
    logic        inj_done;
    logic        init_req;

    logic [31:0] mem [128];
    logic [31:0] snap1 [10];
    logic [31:0] snap2 [10];
    int          azn;
    int          az_pulses = 0;
    int          az_base;
    int          d1_cfg, d2_cfg;
    int          stub_cnt;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    assign az_done        = stub_done | inj_done;
    assign scratch_mem_in = mem[scratch_mem_read_addr];

    int_qlpc_ctrl dut (
        .clock                  (clock),
        .reset                  (reset),
        .start                  (start),
        .done                   (done),
        .az_start               (az_start),
        .az_done                (az_done),
        .mem_grant              (mem_grant),
        .scratch_mem_read_addr  (scratch_mem_read_addr),
        .scratch_mem_in         (scratch_mem_in),
        .scratch_mem_write_addr (scratch_mem_write_addr),
        .scratch_mem_out        (scratch_mem_out),
        .scratch_mem_write_en   (scratch_mem_write_en)
    );

    function automatic logic [31:0] old_val(input int i);
        case (i)
            0:       return 32'h0000_2000;
            1:       return 32'hFFFF_8000;
            2:       return 32'h1234_FFFF;
            default: return 32'h100 * i;
        endcase
    endfunction

    function automatic logic [31:0] new_val(input int i);
        case (i)
            0:       return 32'h0000_4000;
            1:       return 32'hFFFF_8001;
            2:       return 32'h0000_0003;
            default: return 32'h300 * i;
        endcase
    endfunction

    // Hand-derived midpoints of old_val/new_val.
    function automatic logic [31:0] in_val(input int i);
        case (i)
            0:       return 32'h0000_3000;
            1:       return 32'hFFFF_8000;
            2:       return 32'h0000_0000;
            default: return 32'h200 * i;
        endcase
    endfunction

    // Scratch memory, engine result fill and LSP_IN snapshots at each az_start.
    always @(posedge clock) begin
        if (init_req) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'hDEAD_0000 + i;
            for (int i = 0; i < 10; i++) begin
                mem[7'h60 + i] <= old_val(i);
                mem[7'h6A + i] <= new_val(i);
            end
            azn <= 0;
        end else begin
            if (scratch_mem_write_en) mem[scratch_mem_write_addr] <= scratch_mem_out;
            if (az_start) begin
                for (int k = 0; k < 10; k++) begin
                    if (azn == 0) snap1[k] <= mem[7'h50 + k];
                    else          snap2[k] <= mem[7'h50 + k];
                end
                for (int k = 0; k < 11; k++)
                    mem[7'h40 + k] <= (azn == 0) ? (k + 1) : (32'h100 + k);
                azn       <= azn + 1;
                az_pulses <= az_pulses + 1;
            end
        end
    end

    // Engine stub: az_done rises D cycles after the az_start cycle.
    initial begin
        stub_done = 1'b0;
        stub_cnt  = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                stub_cnt  = 0;
                stub_done = 1'b0;
            end else begin
                if (stub_cnt > 0) begin
                    stub_cnt  = stub_cnt - 1;
                    stub_done = (stub_cnt == 0);
                end else begin
                    stub_done = 1'b0;
                end
                if (az_start) stub_cnt = ((az_pulses - az_base) == 0) ? d1_cfg : d2_cfg;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " az_start"}, {31'd0, az_start}, 32'd0);
        chk({tag, " mem_grant"}, {31'd0, mem_grant}, 32'd0);
        chk({tag, " we"}, {31'd0, scratch_mem_write_en}, 32'd0);
        chk({tag, " raddr"}, {25'd0, scratch_mem_read_addr}, 32'd0);
        chk({tag, " waddr"}, {25'd0, scratch_mem_write_addr}, 32'd0);
        chk({tag, " wdata"}, scratch_mem_out, 32'd0);
    endtask

    task automatic mem_init(input int d1, input int d2);
        init_req = 1'b1;
        @(negedge clock);
        init_req = 1'b0;
        d1_cfg   = d1;
        d2_cfg   = d2;
        az_base  = az_pulses;
    endtask

    task automatic run(input int d1, input int d2, input bit inj, input string tag);
        int  k;
        bit  seen;
        mem_init(d1, d2);
        start = 1'b1;
        k     = 0;
        seen  = 1'b0;
        while (!seen && k < 300) begin
            @(negedge clock);
            k++;
            if (k == 1) start = 1'b0;
            if (inj) begin
                case (k)
                    5:  inj_done = 1'b1;  // INTERP
                    6:  inj_done = 1'b0;
                    21: inj_done = 1'b1;  // same cycle as az_start
                    22: inj_done = 1'b0;
                    23: start = 1'b1;     // WAIT1
                    24: start = 1'b0;
                    default: ;
                endcase
            end
            if (k == 21) begin
                chk({tag, " AZ1 az_start"}, {31'd0, az_start}, 32'd1);
                chk({tag, " AZ1 mem_grant"}, {31'd0, mem_grant}, 32'd1);
            end
            if (k == 22) begin
                chk({tag, " WAIT1 mem_grant"}, {31'd0, mem_grant}, 32'd1);
                chk({tag, " WAIT1 we"}, {31'd0, scratch_mem_write_en}, 32'd0);
            end
            if (done) seen = 1'b1;
        end
        chk({tag, " done cycle"}, k, 55 + d1 + d2);
        @(negedge clock);
        chk({tag, " done one-shot"}, {31'd0, done}, 32'd0);
        chk({tag, " idle mem_grant"}, {31'd0, mem_grant}, 32'd0);
        chk({tag, " az_start count"}, az_pulses - az_base, 32'd2);
    endtask

    task automatic check_image(input string tag);
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("%s AZ_OUT[%0d]", tag, k), mem[k], k + 1);
            chk($sformatf("%s AZ_OUT[%0d]", tag, 11 + k), mem[11 + k], 32'h100 + k);
        end
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("%s LSP_IN@AZ1[%0d]", tag, k), snap1[k], in_val(k));
            chk($sformatf("%s LSP_IN@AZ2[%0d]", tag, k), snap2[k], new_val(k));
            chk($sformatf("%s LSP_IN end[%0d]", tag, k), mem[7'h50 + k], new_val(k));
        end
    endtask

    initial begin
        int k;
        reset    = 1'b1;
        start    = 1'b0;
        inj_done = 1'b0;
        init_req = 1'b0;
        d1_cfg   = 3;
        d2_cfg   = 3;
        az_base  = 0;
        repeat (3) @(negedge clock);
        chk_idle("reset");
        reset = 1'b0;
        @(negedge clock);

        run(3, 3, 1'b0, "run33");
        check_image("run33");

        run(1, 5, 1'b0, "run15");
        check_image("run15");

        run(3, 3, 1'b1, "robust");
        check_image("robust");

        // Abort inside WAIT2 (AZ2 at cycle 46, az_done would come at 56).
        mem_init(3, 10);
        start = 1'b1;
        k     = 0;
        while (k < 50) begin
            @(negedge clock);
            k++;
            if (k == 1) start = 1'b0;
        end
        chk("abort WAIT2 mem_grant", {31'd0, mem_grant}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk_idle("abort");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        inj_done = 1'b1;
        @(negedge clock);
        inj_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("late az_done grant %0d", i), {31'd0, mem_grant}, 32'd0);
            chk($sformatf("late az_done done %0d", i), {31'd0, done}, 32'd0);
        end

        run(3, 3, 1'b0, "fresh");
        check_image("fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
